// File: rtl/viterbi_channel_injector_if.sv
// rtl/viterbi_channel_injector_if.sv - coded-symbol stream in/out of the channel injector
interface viterbi_channel_injector_if #(
    parameter int W = 2
);
    logic         valid_i;
    logic [W-1:0] sym_i;
    logic         valid_o;
    logic [W-1:0] sym_o;
    logic [W-1:0] err_o;

    modport master (output valid_i, output sym_i, input valid_o, input sym_o, input err_o);
    modport slave  (input valid_i, input sym_i, output valid_o, output sym_o, output err_o);
endinterface

// File: rtl/viterbi_channel_injector.sv
// rtl/viterbi_channel_injector.sv - noisy channel model: registers coded symbols and flips bits
module viterbi_channel_injector #(
    parameter int          W        = 2,
    parameter int          PERIOD_W = 5,
    parameter int          CNT_W    = 16,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode_i,
    input  logic [PERIOD_W-1:0]     burst_len_i,
    input  logic [15:0]             thresh_i,
    input  logic [W-1:0]            err_mask_i,
    input  logic [CNT_W-1:0]        window_i,
    input  logic                    arm_i,
    input  logic                    clr_i,
    viterbi_channel_injector_if.slave bus,
    output logic [CNT_W-1:0]        sym_ct_o,
    output logic [CNT_W-1:0]        flip_ct_o,
    output logic                    pending_o
);
    localparam int PC_W = $clog2(W + 1);

    logic [PERIOD_W-1:0] phase_q, phase_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic                pending_q, pending_d;
    logic [CNT_W-1:0]    sym_ct_q, sym_ct_d;
    logic [CNT_W-1:0]    flip_ct_q, flip_ct_d;
    logic                valid_q, valid_d;
    logic [W-1:0]        sym_q, sym_d;
    logic [W-1:0]        err_q, err_d;

    logic [PERIOD_W:0]   burst_start;
    logic                inject_raw;
    logic                window_block;
    logic                inject;
    logic [W-1:0]        err;
    logic [PC_W-1:0]     pop;
    logic [CNT_W:0]      flip_sum;
    logic                lfsr_fb;

    // Burst occupies the last burst_len_i phases of each period; 0 puts the start past the end.
    assign burst_start = (PERIOD_W + 1)'(1 << PERIOD_W) - {1'b0, burst_len_i};

    always_comb begin
        inject_raw = 1'b0;
        case (mode_i)
            2'b00:   inject_raw = 1'b0;
            2'b01:   inject_raw = ({1'b0, phase_q} >= burst_start);
            2'b10:   inject_raw = (lfsr_q < thresh_i);
            default: inject_raw = pending_q | arm_i;
        endcase
    end

    assign window_block = (window_i != '0) && (sym_ct_q >= window_i);
    assign inject       = bus.valid_i & inject_raw & ~window_block & ~clr_i;
    assign err          = inject ? err_mask_i : '0;

    always_comb begin
        pop = '0;
        for (int i = 0; i < W; i++) begin
            pop = pop + PC_W'(err[i]);
        end
    end

    assign flip_sum = {1'b0, flip_ct_q} + (CNT_W + 1)'(pop);
    assign lfsr_fb  = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    always_comb begin
        phase_d   = phase_q;
        lfsr_d    = lfsr_q;
        pending_d = pending_q;
        sym_ct_d  = sym_ct_q;
        flip_ct_d = flip_ct_q;
        valid_d   = bus.valid_i;
        sym_d     = sym_q;
        err_d     = err_q;
        if (bus.valid_i) begin
            sym_d = bus.sym_i ^ err;
            err_d = err;
        end
        if (clr_i) begin
            phase_d   = '0;
            lfsr_d    = SEED;
            pending_d = 1'b0;
            sym_ct_d  = '0;
            flip_ct_d = '0;
        end else if (bus.valid_i) begin
            phase_d   = phase_q + 1'b1;
            lfsr_d    = {lfsr_fb, lfsr_q[15:1]};
            sym_ct_d  = (&sym_ct_q) ? sym_ct_q : sym_ct_q + 1'b1;
            flip_ct_d = flip_sum[CNT_W] ? '1 : flip_sum[CNT_W-1:0];
            // Only a single-shot corruption consumes the arm; a window-suppressed symbol leaves it pending.
            pending_d = (pending_q | arm_i) & ~(inject & (mode_i == 2'b11));
        end else begin
            pending_d = pending_q | arm_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q   <= '0;
            lfsr_q    <= SEED;
            pending_q <= 1'b0;
            sym_ct_q  <= '0;
            flip_ct_q <= '0;
            valid_q   <= 1'b0;
            sym_q     <= '0;
            err_q     <= '0;
        end else begin
            phase_q   <= phase_d;
            lfsr_q    <= lfsr_d;
            pending_q <= pending_d;
            sym_ct_q  <= sym_ct_d;
            flip_ct_q <= flip_ct_d;
            valid_q   <= valid_d;
            sym_q     <= sym_d;
            err_q     <= err_d;
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.sym_o   = sym_q;
    assign bus.err_o   = err_q;
    assign sym_ct_o    = sym_ct_q;
    assign flip_ct_o   = flip_ct_q;
    assign pending_o   = pending_q;
endmodule

// File: tb/tb_viterbi_channel_injector.sv
// tb/tb_viterbi_channel_injector.sv - self-checking bench for the channel injector
module tb_viterbi_channel_injector;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [4:0]  blen = '0;
    logic [15:0] thresh = '0;
    logic [1:0]  mask = '0;
    logic [15:0] window = '0;
    logic        arm = 1'b0;
    logic        clr = 1'b0;
    logic        v = 1'b0;
    logic [1:0]  s = '0;

    logic [15:0] ct0, fl0;
    logic [3:0]  ct1, fl1;
    logic        pd0, pd1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    viterbi_channel_injector_if #(.W(2)) bus0 ();
    viterbi_channel_injector_if #(.W(2)) bus1 ();

    assign bus0.valid_i = v;
    assign bus0.sym_i   = s;
    assign bus1.valid_i = v;
    assign bus1.sym_i   = s;

    viterbi_channel_injector #(.W(2), .PERIOD_W(5), .CNT_W(16), .SEED(SEED)) dut0 (
        .clk(clk), .rst(rst), .mode_i(mode), .burst_len_i(blen), .thresh_i(thresh),
        .err_mask_i(mask), .window_i(window), .arm_i(arm), .clr_i(clr), .bus(bus0),
        .sym_ct_o(ct0), .flip_ct_o(fl0), .pending_o(pd0)
    );

    viterbi_channel_injector #(.W(2), .PERIOD_W(5), .CNT_W(4), .SEED(SEED)) dut1 (
        .clk(clk), .rst(rst), .mode_i(mode), .burst_len_i(blen), .thresh_i(thresh),
        .err_mask_i(mask), .window_i(window[3:0]), .arm_i(arm), .clr_i(clr), .bus(bus1),
        .sym_ct_o(ct1), .flip_ct_o(fl1), .pending_o(pd1)
    );

    typedef struct packed {
        logic        v;
        logic [1:0]  sym;
        logic [1:0]  err;
        logic [15:0] ct;
        logic [15:0] fl;
        logic        pend;
    } exp_t;

    typedef struct {
        logic        v, a, c;
        logic [1:0]  s;
        logic        ev;
        logic [1:0]  es, ee;
        logic        ep;
        logic [15:0] ect, efl;
    } vec_t;

    exp_t sbq[$];

    logic [4:0]  m_phase;
    logic [15:0] m_lfsr, m_ct, m_fl;
    logic        m_pend;
    logic [1:0]  m_osym, m_oerr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = '0; m_lfsr = SEED; m_ct = '0; m_fl = '0; m_pend = 1'b0;
        m_osym = '0; m_oerr = '0;
    endtask

    // Drive one cycle, predict outputs into the scoreboard, then compare after the edge.
    task automatic apply(input logic vi, input logic [1:0] si, input logic ai, input logic ci);
        exp_t       e;
        logic       raw, inj;
        logic [1:0] ev;
        int         pc;
        v = vi; s = si; arm = ai; clr = ci;
        case (mode)
            2'b00:   raw = 1'b0;
            2'b01:   raw = (int'(m_phase) >= 32 - int'(blen));
            2'b10:   raw = (m_lfsr < thresh);
            default: raw = m_pend | ai;
        endcase
        inj = vi && raw && !((window != 0) && (m_ct >= window)) && !ci;
        ev  = inj ? mask : 2'b00;
        pc  = int'(ev[0]) + int'(ev[1]);
        if (vi) begin
            m_osym = si ^ ev;
            m_oerr = ev;
        end
        if (ci) begin
            m_phase = '0; m_lfsr = SEED; m_ct = '0; m_fl = '0; m_pend = 1'b0;
        end else if (vi) begin
            m_phase = m_phase + 5'd1;
            m_lfsr  = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
            if (m_ct != 16'hFFFF) m_ct = m_ct + 16'd1;
            m_fl   = (int'(m_fl) + pc > 65535) ? 16'hFFFF : m_fl + 16'(pc);
            m_pend = (m_pend | ai) && !(inj && mode == 2'b11);
        end else begin
            m_pend = m_pend | ai;
        end
        e = '{vi, m_osym, m_oerr, m_ct, m_fl, m_pend};
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("valid_o", bus0.valid_o, e.v);
        chk("sym_o", bus0.sym_o, e.sym);
        chk("err_o", bus0.err_o, e.err);
        chk("sym_ct_o", ct0, e.ct);
        chk("flip_ct_o", fl0, e.fl);
        chk("pending_o", pd0, e.pend);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[12];
        vt[0]  = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0, 16'd0, 16'd0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 16'd0, 16'd0};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 16'd0, 16'd0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 16'd0, 16'd0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 16'd0, 16'd0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 2'b01, 2'b11, 1'b0, 16'd1, 16'd2};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 2'b11, 2'b00, 1'b0, 16'd2, 16'd2};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 2'b11, 2'b11, 1'b0, 16'd3, 16'd4};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 1'b0, 16'd4, 16'd4};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b10, 2'b00, 1'b0, 16'd4, 16'd4};
        vt[10] = '{1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 2'b11, 2'b00, 1'b0, 16'd0, 16'd0};
        vt[11] = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 16'd0, 16'd0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid_o", bus0.valid_o, 1'b0);
        chk("reset sym_o", bus0.sym_o, 2'b00);
        chk("reset err_o", bus0.err_o, 2'b00);
        chk("reset sym_ct_o", ct0, 16'd0);
        chk("reset flip_ct_o", fl0, 16'd0);
        chk("reset pending_o", pd0, 1'b0);
        rst = 1'b1;

        mode = 2'b00; mask = 2'b11;
        for (int i = 0; i < 100; i++) apply(1'b1, 2'($urandom), 1'b0, 1'b0);
        chk("pass sym_ct", ct0, 16'd100);
        chk("pass flip_ct", fl0, 16'd0);

        apply(1'b0, 2'b00, 1'b0, 1'b1);
        mode = 2'b01; blen = 5'd4; mask = 2'b10; window = 16'd256;
        for (int i = 0; i < 300; i++) begin
            apply(1'b1, 2'($urandom), 1'b0, 1'b0);
            chk("burst err_o", bus0.err_o, ((i % 32) >= 28 && i < 256) ? 2'b10 : 2'b00);
            if (i == 255) chk("burst flip_ct@256", fl0, 16'd32);
        end
        chk("burst flip_ct end", fl0, 16'd32);
        chk("burst sym_ct end", ct0, 16'd300);

        apply(1'b0, 2'b00, 1'b0, 1'b1);
        window = '0; mode = 2'b10; thresh = 16'h0000; mask = 2'b01;
        for (int i = 0; i < 500; i++) apply(1'b1, 2'($urandom), 1'b0, 1'b0);
        chk("rand thresh0 flip_ct", fl0, 16'd0);
        apply(1'b0, 2'b00, 1'b0, 1'b1);
        thresh = 16'h1000;
        for (int i = 0; i < 4096; i++) apply(1'b1, 2'($urandom), 1'b0, 1'b0);
        chk("rand 4096 sym_ct", ct0, 16'd4096);

        thresh = 16'h8000; mask = 2'b11;
        apply(1'b1, 2'b01, 1'b0, 1'b0);
        apply(1'b0, 2'b10, 1'b0, 1'b0);
        apply(1'b0, 2'b11, 1'b0, 1'b0);
        apply(1'b1, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) apply(1'($urandom), 2'($urandom), 1'b0, 1'b0);

        mode = 2'b11; mask = 2'b11; window = '0;
        for (int i = 0; i < 12; i++) begin
            apply(vt[i].v, vt[i].s, vt[i].a, vt[i].c);
            chk($sformatf("tbl%0d valid_o", i), bus0.valid_o, vt[i].ev);
            chk($sformatf("tbl%0d sym_o", i), bus0.sym_o, vt[i].es);
            chk($sformatf("tbl%0d err_o", i), bus0.err_o, vt[i].ee);
            chk($sformatf("tbl%0d pending_o", i), pd0, vt[i].ep);
            chk($sformatf("tbl%0d sym_ct_o", i), ct0, vt[i].ect);
            chk($sformatf("tbl%0d flip_ct_o", i), fl0, vt[i].efl);
        end

        apply(1'b0, 2'b00, 1'b0, 1'b1);
        mode = 2'b01; blen = 5'd4; mask = 2'b11;
        for (int i = 0; i < 30; i++) apply(1'b1, 2'($urandom), 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst valid_o", bus0.valid_o, 1'b0);
        chk("midrst sym_o", bus0.sym_o, 2'b00);
        chk("midrst err_o", bus0.err_o, 2'b00);
        chk("midrst sym_ct_o", ct0, 16'd0);
        chk("midrst flip_ct_o", fl0, 16'd0);
        chk("midrst pending_o", pd0, 1'b0);
        chk("midrst dut1 sym_ct_o", ct1, 4'd0);
        model_reset();
        #2;
        rst = 1'b1;

        blen = 5'd31;
        apply(1'b1, 2'b01, 1'b0, 1'b0);
        chk("post-reset phase0 err_o", bus0.err_o, 2'b00);
        apply(1'b1, 2'b01, 1'b0, 1'b0);
        chk("post-reset phase1 err_o", bus0.err_o, 2'b11);
        for (int i = 0; i < 18; i++) apply(1'b1, 2'($urandom), 1'b0, 1'b0);
        chk("sat sym_ct (CNT_W=4)", ct1, 4'd15);
        chk("sat flip_ct (CNT_W=4)", fl1, 4'd15);
        apply(1'b1, 2'b00, 1'b0, 1'b0);
        chk("sat sym_ct hold", ct1, 4'd15);
        chk("sat flip_ct hold", fl1, 4'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
